// File: rtl/int_to_float.sv
// Sequential unsigned-integer to 8-bit mini-float {exp[2:0], mant[4:0]} encoder.
// Half-up rounding is built when INT_TO_FLOAT_ROUND_EN is defined; the default is truncation.
`timescale 1ns/1ps

module int_to_float #(
    parameter int IN_W = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic            sat
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [IN_W-1:0] shreg_q, shreg_d;
    logic [2:0]      exp_q, exp_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            sat_q, sat_d;
    logic            fits;
    logic [7:0]      fin_data;
    logic            fin_sat;
`ifdef INT_TO_FLOAT_ROUND_EN
    logic            round_q, round_d;
    logic [5:0]      mant_r;
`endif

    // Widen before comparing so the constant 32 survives even when IN_W is 5.
    assign fits = (17'(shreg_q) < 17'd32);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        fin_sat  = 1'b0;
`ifdef INT_TO_FLOAT_ROUND_EN
        mant_r   = {1'b0, shreg_q[4:0]} + {5'd0, round_q};
        fin_data = {exp_q, mant_r[4:0]};
        if (mant_r[5]) begin
            if (exp_q == 3'd7) begin
                fin_data = 8'hFF;
                fin_sat  = 1'b1;
            end else begin
                fin_data = {exp_q + 3'd1, 5'd16};
            end
        end
`else
        fin_data = {exp_q, shreg_q[4:0]};
`endif
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        exp_d      = exp_q;
        out_data_d = out_data_q;
        sat_d      = sat_q;
`ifdef INT_TO_FLOAT_ROUND_EN
        round_d    = round_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shreg_d = in_data;
                    exp_d   = 3'd0;
`ifdef INT_TO_FLOAT_ROUND_EN
                    round_d = 1'b0;
`endif
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (fits) begin
                    out_data_d = fin_data;
                    sat_d      = fin_sat;
                    state_d    = ST_DONE;
                end else if (exp_q == 3'd7) begin
                    out_data_d = 8'hFF;
                    sat_d      = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    shreg_d = shreg_q >> 1;
                    exp_d   = exp_q + 3'd1;
`ifdef INT_TO_FLOAT_ROUND_EN
                    round_d = shreg_q[0];
`endif
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            exp_q      <= 3'd0;
            out_data_q <= 8'h00;
            sat_q      <= 1'b0;
`ifdef INT_TO_FLOAT_ROUND_EN
            round_q    <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            exp_q      <= exp_d;
            out_data_q <= out_data_d;
            sat_q      <= sat_d;
`ifdef INT_TO_FLOAT_ROUND_EN
            round_q    <= round_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = out_data_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_int_to_float.sv
// Self-checking bench for int_to_float: an IN_W=12 instance for most scenarios and an
// IN_W=16 instance for true saturation; expected results come from an arithmetic model.
`timescale 1ns/1ps

module tb_int_to_float;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        sat;

    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic [15:0] in_data16 = '0;
    logic        out_valid16;
    logic        out_ready16 = 1'b1;
    logic [7:0]  out_data16;
    logic        sat16;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    int_to_float #(.IN_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .sat(sat)
    );

    int_to_float #(.IN_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16), .sat(sat16)
    );

    // Reference: smallest exponent e with v/2^e < 32, mantissa v/2^e, optional half-up on the last dropped bit.
    function automatic void model(input int unsigned v, output logic [7:0] d,
                                  output logic s, output int lat);
        int e;
        int unsigned m;
        logic [2:0] e3;
        logic [4:0] m5;
        e = 0;
        while (e < 7 && (v >> e) >= 32) e++;
        if ((v >> e) >= 32) begin
            d = 8'hFF; s = 1'b1; lat = 8;
            return;
        end
        lat = e + 1;
        m = v >> e;
        s = 1'b0;
`ifdef INT_TO_FLOAT_ROUND_EN
        if (e > 0) m = m + ((v >> (e - 1)) & 1);
        if (m == 32) begin
            if (e == 7) begin
                d = 8'hFF; s = 1'b1;
                return;
            end
            e = e + 1;
            m = 16;
        end
`endif
        e3 = e[2:0];
        m5 = m[4:0];
        d = {e3, m5};
    endfunction

    // Accept v at edge E0 and count edges until out_valid is first seen.
    task automatic conv12(input logic [15:0] v, output logic [7:0] d, output logic s,
                          output int lat, output bit timeout);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v[11:0];
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        timeout = !out_valid;
        d = out_data;
        s = sat;
    endtask

    task automatic run_value(input string name, input logic [15:0] v);
        logic [7:0] ed, d;
        logic es, s;
        int elat, lat;
        bit to;
        model(int'(v), ed, es, elat);
        conv12(v, d, s, lat, to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL %s timeout: in=%0d out_valid never rose", name, v);
        end
        n_checks++;
        if (d !== ed) begin
            n_fail++;
            $display("FAIL %s out_data: in=%0d got %h expected %h", name, v, d, ed);
        end
        n_checks++;
        if (s !== es) begin
            n_fail++;
            $display("FAIL %s sat: in=%0d got %b expected %b", name, v, s, es);
        end
        n_checks++;
        if (lat != elat) begin
            n_fail++;
            $display("FAIL %s latency: in=%0d got %0d expected %0d", name, v, lat, elat);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s return_idle: out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if ({in_ready, out_valid, out_data, sat} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b data=%h sat=%b expected 1 0 00 0",
                     in_ready, out_valid, out_data, sat);
        end
        n_checks++;
        if ({in_ready16, out_valid16, out_data16, sat16} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state16: rdy=%b vld=%b data=%h sat=%b expected 1 0 00 0",
                     in_ready16, out_valid16, out_data16, sat16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        run_value("zero", 16'd0);
        run_value("direct19", 16'd19);
        run_value("edge31", 16'd31);
        run_value("edge32", 16'd32);
        run_value("shift103", 16'd103);
        run_value("max4095", 16'd4095);
        run_value("v2000", 16'd2000);
        run_value("v63", 16'd63);
    endtask

    task automatic test_random;
        logic [15:0] v;
        for (int i = 0; i < 40; i++) begin
            v = 16'($urandom_range(0, 4095) >> $urandom_range(0, 11));
            run_value("random", v);
        end
    endtask

    task automatic test_saturation;
        int lat;
        @(negedge clk);
        in_valid16 = 1'b1;
        in_data16  = 16'h1000;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 0;
        while (!out_valid16 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (out_data16 !== 8'hFF || sat16 !== 1'b1) begin
            n_fail++;
            $display("FAIL saturation_value: data=%h sat=%b expected ff 1", out_data16, sat16);
        end
        n_checks++;
        if (lat != 8) begin
            n_fail++;
            $display("FAIL saturation_latency: got %0d expected 8", lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        logic [7:0] ed, d, ed2, d2;
        logic es, s, es2, s2;
        int elat, lat;
        bit to;
        model(103, ed, es, elat);
        model(700, ed2, es2, elat);
        @(negedge clk);
        out_ready = 1'b0;
        conv12(16'd103, d, s, lat, to);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 12'd700;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== ed || sat !== es || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold: vld=%b data=%h sat=%b rdy=%b expected 1 %h %b 0",
                         out_valid, out_data, sat, in_ready, ed, es);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: vld=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_accept2: in_ready=%b expected 0", in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        d2 = out_data;
        s2 = sat;
        n_checks++;
        if (d2 !== ed2 || s2 !== es2) begin
            n_fail++;
            $display("FAIL backpressure_second: data=%h sat=%b expected %h %b", d2, s2, ed2, es2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [7:0] ed1, ed2;
        logic es1, es2;
        int elat, n;
        model(103, ed1, es1, elat);
        model(19, ed2, es2, elat);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 12'd103;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (out_data !== ed1 || sat !== es1) begin
            n_fail++;
            $display("FAIL b2b_first: data=%h sat=%b expected %h %b", out_data, sat, ed1, es1);
        end
        @(negedge clk);
        in_data = 12'd19;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_gap: vld=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_data !== ed2 || sat !== es2 || n != 2) begin
            n_fail++;
            $display("FAIL b2b_second: data=%h sat=%b edges=%0d expected %h %b 2", out_data, sat, n, ed2, es2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        bit seen;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 12'd2000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: vld=%b data=%h rdy=%b expected 0 00 1", out_valid, out_data, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_stale: out_valid rose after reset, expected 0");
        end
        run_value("after_reset5", 16'd5);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
